// File: rtl/ddr3_cmd_arbiter_pkg.sv
// Shared definitions for the DDR3 command arbiter: command codes, FSM states, default widths.
// No logic here; imported by the arbiter and its bench.
// Backpressure behaviour is defined in the arbiter itself.
package ddr3_cmd_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 28;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_RD_TIMEOUT = 1023;
    localparam int LEN_W          = 6;

    localparam logic [2:0] CMD_WR = 3'd0;
    localparam logic [2:0] CMD_RD = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_CMD  = 3'd1,
        S_WR_DATA = 3'd2,
        S_RD_CMD  = 3'd3,
        S_RD_DATA = 3'd4
    } state_t;

endpackage

// File: rtl/ddr3_cmd_arbiter.sv
// Arbitrates one write and one read requester onto a DDR3 app command/data port, one burst at a time.
// Latency: command 1 cycle after request; write beats pass through combinationally; read beats +1 cycle.
// Backpressure: cmd_en held until cmd_ready; write beats follow wr_data_rdy; reads guarded by a watchdog.
module ddr3_cmd_arbiter
    import ddr3_cmd_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
    input  logic                    video_clk,
    input  logic                    rst_n,
    input  logic                    init_calib_complete,
    input  logic                    wr_req,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [5:0]              wr_len,
    output logic                    wr_gnt,
    output logic                    wr_pop,
    input  logic [DATA_WIDTH-1:0]   wr_din,
    output logic                    wr_done,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [5:0]              rd_len,
    input  logic                    rd_urgent,
    output logic                    rd_gnt,
    output logic [DATA_WIDTH-1:0]   rd_dout,
    output logic                    rd_dvalid,
    output logic                    rd_done,
    output logic                    rd_err,
    input  logic                    cmd_ready,
    output logic [2:0]              cmd,
    output logic                    cmd_en,
    output logic [5:0]              app_burst_number,
    output logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    wr_data_rdy,
    output logic                    wr_data_en,
    output logic                    wr_data_end,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_data_mask,
    input  logic                    rd_data_valid,
    input  logic                    rd_data_end,
    input  logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int WD_W = $clog2(RD_TIMEOUT + 1);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LEN_W-1:0]        r_len;
    logic [2:0]              r_cmd;
    logic                    r_last_rd;   // 1: read was served last, so a write wins the next tie
    logic [LEN_W-1:0]        r_beat;
    logic [WD_W-1:0]         r_wdog;
    logic                    r_rd_last;   // final read beat seen, draining its registered copy
    logic                    r_wr_done;
    logic                    r_rd_done;
    logic                    r_rd_err;
    logic                    r_rd_dvalid;
    logic [DATA_WIDTH-1:0]   r_rd_dout;

    logic                    w_in_cmd;
    logic                    w_wr_beat;
    logic                    w_rd_beat;
    logic                    w_wd_expired;
    logic                    w_unused;

    // The end marker only mirrors the beat count we already track.
    assign w_unused     = rd_data_end;

    assign w_in_cmd     = (r_state == S_WR_CMD) || (r_state == S_RD_CMD);
    assign w_wr_beat    = (r_state == S_WR_DATA) && wr_data_rdy;
    assign w_rd_beat    = (r_state == S_RD_DATA) && !r_rd_last && rd_data_valid;
    assign w_wd_expired = (r_state == S_RD_DATA) && !r_rd_last && !rd_data_valid
                          && (r_wdog == WD_W'(RD_TIMEOUT));

    assign cmd_en           = w_in_cmd;
    assign cmd              = r_cmd;
    assign addr             = r_addr;
    assign app_burst_number = r_len;
    assign wr_gnt           = (r_state == S_WR_CMD) && cmd_ready;
    assign rd_gnt           = (r_state == S_RD_CMD) && cmd_ready;

    assign wr_data_en   = w_wr_beat;
    assign wr_pop       = w_wr_beat;
    assign wr_data_end  = w_wr_beat && (r_beat == r_len);
    assign wr_data      = wr_din;
    assign wr_data_mask = '0;

    assign wr_done   = r_wr_done;
    assign rd_done   = r_rd_done;
    assign rd_err    = r_rd_err;
    assign rd_dvalid = r_rd_dvalid;
    assign rd_dout   = r_rd_dout;

    // Burst FSM: arbitration, command latch, beat counting, read watchdog and registered pulses.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_cmd       <= CMD_WR;
            r_last_rd   <= 1'b1;
            r_beat      <= '0;
            r_wdog      <= '0;
            r_rd_last   <= 1'b0;
            r_wr_done   <= 1'b0;
            r_rd_done   <= 1'b0;
            r_rd_err    <= 1'b0;
            r_rd_dvalid <= 1'b0;
            r_rd_dout   <= '0;
        end else begin
            r_wr_done   <= 1'b0;
            r_rd_done   <= 1'b0;
            r_rd_dvalid <= w_rd_beat;
            if (w_rd_beat) begin
                r_rd_dout <= rd_data;
            end

            case (r_state)
                S_IDLE: begin
                    r_beat    <= '0;
                    r_wdog    <= '0;
                    r_rd_last <= 1'b0;
                    if (init_calib_complete) begin
                        // Urgent read first, then round-robin on a tie, else whoever asks.
                        if (rd_req && (rd_urgent || !wr_req || !r_last_rd)) begin
                            r_addr  <= rd_addr;
                            r_len   <= rd_len;
                            r_cmd   <= CMD_RD;
                            r_state <= S_RD_CMD;
                        end else if (wr_req) begin
                            r_addr  <= wr_addr;
                            r_len   <= wr_len;
                            r_cmd   <= CMD_WR;
                            r_state <= S_WR_CMD;
                        end
                    end
                end
                S_WR_CMD: begin
                    if (cmd_ready) begin
                        r_last_rd <= 1'b0;
                        r_state   <= S_WR_DATA;
                    end
                end
                S_RD_CMD: begin
                    if (cmd_ready) begin
                        r_last_rd <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (w_wr_beat) begin
                        if (r_beat == r_len) begin
                            r_wr_done <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + 6'd1;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (r_rd_last) begin
                        // Final rd_dvalid is on the output now; done follows it.
                        r_rd_done <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_rd_beat) begin
                        r_wdog <= '0;
                        if (r_beat == r_len) begin
                            r_rd_last <= 1'b1;
                        end else begin
                            r_beat <= r_beat + 6'd1;
                        end
                    end else if (w_wd_expired) begin
                        r_rd_err  <= 1'b1;
                        r_rd_done <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ddr3_cmd_arbiter.md
DDR3_CMD_ARBITER -- requirements
Module: ddr3_cmd_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 28, DDR3 byte address width; DATA_WIDTH, default 128, application data width; RD_TIMEOUT, default 1023, maximum cycles allowed between read beats.
REQ-002 SHALL have ports, listed as name, direction, width, meaning:
 - video_clk, in, 1, sole clock.
 - rst_n, in, 1, reset: asynchronous, active-low.
 - init_calib_complete, in, 1, DDR3 calibration done.
 - wr_req, in, 1, write requester wants a burst.
 - wr_addr, in, ADDR_WIDTH, burst address.
 - wr_len, in, 6, beats minus 1.
 - wr_gnt, out, 1, one-cycle pulse when the write command is accepted.
 - wr_pop, out, 1, requester supplies the next beat on wr_din this cycle.
 - wr_din, in, DATA_WIDTH, write beat data.
 - wr_done, out, 1, one-cycle pulse after the last write beat.
 - rd_req, in, 1, read requester wants a burst.
 - rd_addr, in, ADDR_WIDTH, burst address.
 - rd_len, in, 6, beats minus 1.
 - rd_urgent, in, 1, read FIFO low-water flag.
 - rd_gnt, out, 1, one-cycle pulse when the read command is accepted.
 - rd_dout, out, DATA_WIDTH, read beat data.
 - rd_dvalid, out, 1, rd_dout is valid.
 - rd_done, out, 1, one-cycle pulse after the last read beat.
 - rd_err, out, 1, sticky read-timeout flag.
 - cmd_ready, in, 1, memory controller accepts a command.
 - cmd, out, 3, 0 = write, 1 = read.
 - cmd_en, out, 1, command strobe.
 - app_burst_number, out, 6, beats minus 1.
 - addr, out, ADDR_WIDTH, command address.
 - wr_data_rdy, in, 1, controller accepts a write beat.
 - wr_data_en, out, 1, write beat strobe.
 - wr_data_end, out, 1, write beat end marker.
 - wr_data, out, DATA_WIDTH, write beat data.
 - wr_data_mask, out, DATA_WIDTH/8, byte mask.
 - rd_data_valid, in, 1, read beat valid.
 - rd_data_end, in, 1, unused.
 - rd_data, in, DATA_WIDTH, read beat data.

Function
REQ-003 SHALL implement the FSM states IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA; only one burst SHALL be outstanding at a time.
REQ-004 IDLE SHALL stay in IDLE while init_calib_complete=0; while it is 0, all requests SHALL be ignored and no grants issued.
REQ-005 IDLE arbitration SHALL follow this order:
 - rd_req and rd_urgent both set -> RD_CMD.
 - Otherwise, if both requests are set, round-robin against last_grant; the requester that was not served last wins.
 - Otherwise, the single active requester wins.
REQ-006 On entering a CMD state, the arbiter SHALL latch addr and len from the winning requester into internal registers; requester inputs SHALL NOT be sampled again until the next IDLE.
REQ-007 In a CMD state, cmd_en SHALL be asserted continuously with cmd, addr and app_burst_number driven from the latches. The command SHALL be accepted on the first cycle with cmd_en=1 and cmd_ready=1. In that cycle the arbiter SHALL pulse the matching gnt, update last_grant, and move to the DATA state on the next cycle.
REQ-008 In WR_DATA:
 - wr_data_en = wr_data_rdy, and wr_pop = wr_data_en (combinational).
 - wr_data = wr_din; wr_data_mask = 0.
 - A beat counter SHALL increment per accepted beat.
 - wr_data_end SHALL assert with the beat where the count equals the latched len.
 - After that beat, the arbiter SHALL pulse wr_done and return to IDLE.
REQ-009 In RD_DATA:
 - rd_dvalid = rd_data_valid and rd_dout = rd_data, both registered, giving 1 cycle of latency.
 - The arbiter SHALL count beats; rd_done SHALL pulse one cycle after the final rd_dvalid, and the FSM SHALL then return to IDLE.
REQ-010 A read watchdog counter SHALL reset on each rd_data_valid. When it reaches RD_TIMEOUT in RD_DATA, the arbiter SHALL set rd_err (sticky until reset), pulse rd_done and return to IDLE.
REQ-011 rd_data_valid outside RD_DATA SHALL be ignored and SHALL NOT generate rd_dvalid.
REQ-012 A len of 0 SHALL mean a one-beat burst; wr_data_end SHALL then coincide with the first beat.
REQ-013 If init_calib_complete deasserts mid-burst, the current burst SHALL complete; IDLE SHALL then hold off further grants.

Reset
REQ-014 While rst_n=0, the arbiter SHALL hold:
 - state IDLE and last_grant = read, so a write wins the first tie.
 - All counters at 0 and rd_err = 0.
 - cmd_en, wr_data_en, wr_data_end, wr_pop, all gnt and done pulses, and rd_dvalid all 0.
 - cmd = 0, addr = 0, app_burst_number = 0, rd_dout = 0.
REQ-015 Reset assertion mid-burst SHALL abort the burst immediately with no further strobes; reset release SHALL be synchronised by the user.

Structure
REQ-016 A shared package SHALL hold the command encodings (CMD_WR = 3'd0, CMD_RD = 3'd1), the FSM state encoding, and the default widths.
REQ-017 The design SHALL be a single module with no sub-modules; the beat counter and watchdog counter are internal registers.

Verification
REQ-018 Write burst: wr_req, wr_len=3, cmd_ready=1, wr_data_rdy toggling 1,0,1,1,1 -> one cmd_en with cmd=0 and app_burst_number=3; exactly 4 wr_data_en; wr_data_end on the 4th; one wr_done.
REQ-019 Simultaneous wr_req and rd_req held high for 4 bursts -> grants alternate W,R,W,R starting with write.
REQ-020 rd_urgent=1 while both requests are pending after a read -> read is granted again, overriding round-robin.
REQ-021 Read burst with rd_len=7 and 8 rd_data_valid beats with gaps -> 8 rd_dvalid pulses, each 1 cycle after its input beat; rd_done one cycle after the last; rd_err=0.
REQ-022 Read with only 2 of 4 beats returned -> rd_err=1 and rd_done after RD_TIMEOUT idle cycles, FSM back in IDLE; the next write is granted normally.
REQ-023 rst_n pulsed low during WR_DATA beat 2 -> all outputs at reset values within the same cycle; with init_calib_complete=0 after release, no cmd_en is issued.
